// File: rtl/dump_ctrl_pkg.sv
// Shared capture package.
// Holds the trace address type, the trace depth, the dump state encoding
// and a small address helper used by the capture and dump logic.
`timescale 1ns/1ps
package dump_ctrl_pkg;

    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned TRACE_DEPTH = 512;

    typedef logic [ADDR_W-1:0] addr_t;

    // Index of the final sample of a full trace (count value that ends a dump).
    localparam addr_t LAST_SAMPLE = addr_t'(TRACE_DEPTH - 1);

    // Channel code that is reserved and must be rejected.
    localparam logic [1:0] CHAN_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DONE    = 3'd5
    } dump_state_t;

    // Next trace address; the trace RAM is circular, so 0x1FF rolls to 0x000.
    function automatic addr_t addr_inc(input addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams one captured 512-sample trace from a selected channel
// RAM to a UART transmitter, oldest sample first.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_dump            request to dump the held trace (acted on in IDLE only)
//   dump_chan             channel select 0..2 (3 is reserved and rejected)
//   capture_done          a completed trace is held in RAM
//   trace_end             address of the last sample written
//   ram_rdata0..2         synchronous RAM read data (1-cycle latency)
//   ram_en, ram_addr      RAM read enable and address
//   tx_data, send_dump    byte to the UART and its one-cycle strobe
//   tx_done               UART byte-complete pulse (honoured in WAIT_TX only)
//   dump_finished         one-cycle pulse at the end of a dump
//   clr_capture_done      one-cycle pulse coincident with dump_finished
//   dump_err              one-cycle pulse when a start request is rejected
//
// All outputs are registers. Pulse outputs default low every cycle and are
// raised on the transition into the state in which they must be seen, so
// ram_en is high exactly in READ, send_dump in SEND and dump_finished in DONE.
`timescale 1ns/1ps
module dump_ctrl
    import dump_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_dump,
    input  logic [1:0]  dump_chan,
    input  logic        capture_done,
    input  addr_t       trace_end,
    input  logic [7:0]  ram_rdata0,
    input  logic [7:0]  ram_rdata1,
    input  logic [7:0]  ram_rdata2,
    output logic        ram_en,
    output addr_t       ram_addr,
    output logic [7:0]  tx_data,
    output logic        send_dump,
    input  logic        tx_done,
    output logic        dump_finished,
    output logic        clr_capture_done,
    output logic        dump_err
);

    dump_state_t state_r;
    addr_t       count_r;
    logic [1:0]  chan_r;
    logic [7:0]  sel_data_s;
    logic        start_ok_s;

    // A start is accepted only with a trace held and a non-reserved channel.
    assign start_ok_s = capture_done && (dump_chan != CHAN_RESERVED);

    // Select the read data of the channel registered at dump start.
    always_comb begin
        sel_data_s = 8'h00;
        case (chan_r)
            2'd0:    sel_data_s = ram_rdata0;
            2'd1:    sel_data_s = ram_rdata1;
            2'd2:    sel_data_s = ram_rdata2;
            default: sel_data_s = 8'h00;
        endcase
    end

    // Dump sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            count_r          <= 9'd0;
            chan_r           <= 2'd0;
            ram_en           <= 1'b0;
            ram_addr         <= 9'd0;
            tx_data          <= 8'h00;
            send_dump        <= 1'b0;
            dump_finished    <= 1'b0;
            clr_capture_done <= 1'b0;
            dump_err         <= 1'b0;
        end else begin
            ram_en           <= 1'b0;
            send_dump        <= 1'b0;
            dump_finished    <= 1'b0;
            clr_capture_done <= 1'b0;
            dump_err         <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start_dump) begin
                        if (start_ok_s) begin
                            // Oldest sample sits just after the last one written.
                            ram_addr <= addr_inc(trace_end);
                            count_r  <= 9'd0;
                            chan_r   <= dump_chan;
                            ram_en   <= 1'b1;
                            state_r  <= ST_READ;
                        end else begin
                            dump_err <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_READ: begin
                    state_r <= ST_LATCH;
                end

                ST_LATCH: begin
                    // RAM data for the address issued in READ is valid now.
                    tx_data   <= sel_data_s;
                    send_dump <= 1'b1;
                    state_r   <= ST_SEND;
                end

                ST_SEND: begin
                    state_r <= ST_WAIT_TX;
                end

                ST_WAIT_TX: begin
                    if (tx_done) begin
                        if (count_r == LAST_SAMPLE) begin
                            dump_finished    <= 1'b1;
                            clr_capture_done <= 1'b1;
                            state_r          <= ST_DONE;
                        end else begin
                            count_r  <= count_r + 9'd1;
                            ram_addr <= addr_inc(ram_addr);
                            ram_en   <= 1'b1;
                            state_r  <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_WAIT_TX;
                    end
                end

                ST_DONE: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dump_ctrl.sv
// Self-checking bench for dump_ctrl: RAM and UART models, a scoreboard fed by
// a reference model of the dump order, and a monitor that checks every RAM
// read and every transmitted byte.
`timescale 1ns/1ps
module tb_dump_ctrl;
    import dump_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_dump = 1'b0;
    logic [1:0]  dump_chan = 2'd0;
    logic        capture_done = 1'b0;
    logic [8:0]  trace_end = 9'd0;
    logic [7:0]  ram_rdata0, ram_rdata1, ram_rdata2;
    logic        ram_en;
    logic [8:0]  ram_addr;
    logic [7:0]  tx_data;
    logic        send_dump;
    logic        tx_done = 1'b0;
    logic        dump_finished;
    logic        clr_capture_done;
    logic        dump_err;

    dump_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .dump_chan(dump_chan),
        .capture_done(capture_done), .trace_end(trace_end),
        .ram_rdata0(ram_rdata0), .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2),
        .ram_en(ram_en), .ram_addr(ram_addr), .tx_data(tx_data), .send_dump(send_dump),
        .tx_done(tx_done), .dump_finished(dump_finished),
        .clr_capture_done(clr_capture_done), .dump_err(dump_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel RAM contents and synchronous read model.
    logic [7:0] mem0 [TRACE_DEPTH];
    logic [7:0] mem1 [TRACE_DEPTH];
    logic [7:0] mem2 [TRACE_DEPTH];

    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata0 <= mem0[ram_addr];
            ram_rdata1 <= mem1[ram_addr];
            ram_rdata2 <= mem2[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int n_send = 0, n_en = 0, n_fin = 0, n_err = 0;
    logic [8:0] first_addr, last_addr;
    bit first_seen = 1'b0;
    bit armed = 1'b0;
    int done_cyc = 0;
    int uart_delay = 2;       // 0 selects a random delay of 1..4 cycles
    bit spurious_en = 1'b0;

    logic [7:0] exp_data [$];
    logic [8:0] exp_addr [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [1:0] ch, input int a);
        case (ch)
            2'd0:    return mem0[a];
            2'd1:    return mem1[a];
            2'd2:    return mem2[a];
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: 512 samples, oldest first, starting just past trace_end.
    task automatic prep_expect(input logic [8:0] te, input logic [1:0] ch);
        for (int i = 0; i < TRACE_DEPTH; i++) begin
            int a;
            a = (int'(te) + 1 + i) % TRACE_DEPTH;
            exp_addr.push_back(9'(a));
            exp_data.push_back(mem_rd(ch, a));
        end
    endtask

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (send_dump) begin
                n_send++;
                check("send_expected", 32'(exp_data.size() != 0), 32'd1);
                if (exp_data.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_data.pop_front()));
                if (armed) begin
                    check("tx_done_to_send", 32'(cyc - done_cyc), 32'd3);
                    armed = 1'b0;
                end
            end
            if (ram_en) begin
                n_en++;
                if (!first_seen) first_addr = ram_addr;
                first_seen = 1'b1;
                last_addr = ram_addr;
                check("ram_en_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) check("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
            end
            if (dump_finished || clr_capture_done) begin
                check("clr_with_finished", 32'(clr_capture_done), 32'(dump_finished));
            end
            if (dump_finished) begin
                n_fin++;
                armed = 1'b0;
            end
            if (dump_err) n_err++;
        end
    end

    // UART model: answers each send_dump with a one-cycle tx_done, optionally
    // preceded by a spurious tx_done while the DUT is still in SEND.
    initial begin
        forever begin
            @(negedge clk);
            if (send_dump && rst_n) begin
                int d;
                d = (uart_delay == 0) ? int'($urandom_range(1, 4)) : uart_delay;
                tx_done = spurious_en && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                tx_done = 1'b0;
                repeat (d - 1) @(negedge clk);
                tx_done = 1'b1;
                done_cyc = cyc;
                armed = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_send_dump"}, 32'(send_dump), 32'd0);
        check({tag, "_dump_finished"}, 32'(dump_finished), 32'd0);
        check({tag, "_clr_capture_done"}, 32'(clr_capture_done), 32'd0);
        check({tag, "_dump_err"}, 32'(dump_err), 32'd0);
    endtask

    task automatic pulse_start(input logic [8:0] te, input logic [1:0] ch);
        @(negedge clk);
        trace_end = te;
        dump_chan = ch;
        capture_done = 1'b1;
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
    endtask

    task automatic do_dump(input logic [8:0] te, input logic [1:0] ch, input bit busy);
        int s0, e0, f0, r0, t;
        s0 = n_send; e0 = n_en; f0 = n_fin; r0 = n_err;
        first_seen = 1'b0;
        prep_expect(te, ch);
        pulse_start(te, ch);
        t = 0;
        while (n_fin == f0 && t < 8000) begin
            @(negedge clk);
            t++;
            if (busy && t == 300) begin
                start_dump = 1'b1;
                dump_chan = 2'd2;
            end else if (busy && t == 301) begin
                start_dump = 1'b0;
            end
        end
        check("dump_in_time", 32'(t < 8000), 32'd1);
        capture_done = 1'b0;
        repeat (4) @(negedge clk);
        check("bytes_sent", 32'(n_send - s0), 32'd512);
        check("ram_reads", 32'(n_en - e0), 32'd512);
        check("finished_pulses", 32'(n_fin - f0), 32'd1);
        check("no_err_in_dump", 32'(n_err - r0), 32'd0);
        check("first_addr", 32'(first_addr), 32'(9'(te + 9'd1)));
        check("last_addr", 32'(last_addr), 32'(te));
        check("queue_drained", 32'(exp_data.size() + exp_addr.size()), 32'd0);
        exp_data.delete();
        exp_addr.delete();
    endtask

    task automatic do_reject(input logic cd, input logic [1:0] ch);
        int e0, r0;
        e0 = n_en; r0 = n_err;
        @(negedge clk);
        capture_done = cd;
        dump_chan = ch;
        start_dump = 1'b1;
        @(negedge clk);
        start_dump = 1'b0;
        repeat (4) @(negedge clk);
        check("reject_err_pulses", 32'(n_err - r0), 32'd1);
        check("reject_no_ram_en", 32'(n_en - e0), 32'd0);
        capture_done = 1'b0;
    endtask

    initial begin
        int s0, f0, t;
        for (int i = 0; i < TRACE_DEPTH; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
            mem2[i] = 8'($urandom);
        end

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_reject(1'b0, 2'd1);
        do_reject(1'b1, 2'd3);

        uart_delay = 2;
        do_dump(9'h0FF, 2'd1, 1'b0);

        uart_delay = 0;
        spurious_en = 1'b1;
        do_dump(9'h1FF, 2'd2, 1'b0);
        do_dump(9'h1FE, 2'd0, 1'b0);
        do_dump(9'($urandom), 2'd0, 1'b1);

        // Reset in the middle of a dump, then restart the same trace.
        spurious_en = 1'b0;
        s0 = n_send; f0 = n_fin;
        prep_expect(9'h0A5, 2'd1);
        pulse_start(9'h0A5, 2'd1);
        t = 0;
        while ((n_send - s0) < 100 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("reached_byte_100", 32'(t < 3000), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_data.delete();
        exp_addr.delete();
        repeat (5) @(negedge clk);
        check_outputs_zero("held_reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        armed = 1'b0;
        check("no_finish_on_abort", 32'(n_fin - f0), 32'd0);
        do_dump(9'h0A5, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset, as the following two ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.

REQ-002 The block SHALL have the following further ports:
- start_dump  in  1  request to dump one captured trace; sampled each clk.
- dump_chan  in  2  channel select; 0,1,2 valid, 3 reserved.
- capture_done  in  1  a completed trace is held in RAM.
- trace_end  in  9  address of the last sample written.
- ram_rdata0  in  8  read data, channel-0 RAM.
- ram_rdata1  in  8  read data, channel-1 RAM.
- ram_rdata2  in  8  read data, channel-2 RAM.
- ram_en  out  1  RAM read enable; the RAMs are synchronous, with 1-cycle read latency.
- ram_addr  out  9  RAM read address.
- tx_data  out  8  byte to the UART transmitter.
- send_dump  out  1  one-cycle strobe; tx_data is valid while it is high.
- tx_done  in  1  one-cycle pulse from the UART when a byte has finished.
- dump_finished  out  1  one-cycle pulse when the dump completes.
- clr_capture_done  out  1  one-cycle pulse, coincident with dump_finished.
- dump_err  out  1  one-cycle pulse when a start request is rejected.

Function
REQ-003 States SHALL be IDLE, READ, LATCH, SEND, WAIT_TX and DONE; an illegal state SHALL go to IDLE.

REQ-004 In IDLE, start_dump=1 with capture_done=1 and dump_chan<3 SHALL do all of the following:
- load ram_addr = trace_end+1 (9-bit wrap);
- clear the 9-bit sample count;
- register dump_chan as the active channel;
- go to READ.

REQ-005 In IDLE, start_dump=1 with capture_done=0 or dump_chan=3 SHALL pulse dump_err for one cycle and remain in IDLE.

REQ-006 READ SHALL assert ram_en for exactly one cycle and go to LATCH.

REQ-007 LATCH SHALL register the ram_rdata of the active channel into tx_data and go to SEND.

REQ-008 SEND SHALL assert send_dump for exactly one cycle and go to WAIT_TX.

REQ-009 WAIT_TX SHALL hold until tx_done=1, then:
- if sample count = 511, go to DONE;
- otherwise increment the sample count, set ram_addr = ram_addr+1 (wrap 0x1FF->0x000), and go to READ.

REQ-010 DONE SHALL pulse dump_finished and clr_capture_done for one cycle, then go to IDLE.

REQ-011 Exactly 512 bytes SHALL be sent per dump, oldest first, in the order trace_end+1 ... trace_end.

REQ-012 The dump_chan input SHALL be ignored outside IDLE; the registered active channel SHALL be used for the whole dump.

REQ-013 The start_dump input SHALL be ignored outside IDLE; a start request SHALL NOT be queued.

REQ-014 tx_done received in any state other than WAIT_TX SHALL be ignored.

REQ-015 tx_data SHALL hold its value from LATCH until the next LATCH.

REQ-016 ram_en SHALL be 0 in every state except READ.

REQ-017 Minimum per-byte latency SHALL be 4 cycles plus the UART time: tx_done to the next send_dump = 3 cycles.

Reset
REQ-018 Asserting rst_n=0 at any time, including mid-dump, SHALL force IDLE and abort the dump without pulsing dump_finished.

REQ-019 During and after reset, outputs SHALL be 0: ram_en, ram_addr, tx_data, send_dump, dump_finished, clr_capture_done, dump_err.

REQ-020 The sample count and active channel SHALL reset to 0.

Structure
REQ-021 The Address type (9-bit), the constant TRACE_DEPTH=512 and the dump state enum SHALL live in the shared capture package used by the capture logic.

REQ-022 The block SHALL be a single module with no sub-modules; the three RAMs and the UART are external.

Verification
REQ-023 Normal dump: trace_end=0x0FF, capture_done=1, chan=1, tx_done 2 cycles after each send_dump -> 512 send_dump pulses; the first byte is from ram_addr 0x100 and the last from 0x0FF; one dump_finished and clr_capture_done pulse.

REQ-024 Wrap: trace_end=0x1FF -> the first ram_addr is 0x000 and the last is 0x1FF; a trace_end=0x1FE dump shows the 0x1FF->0x000 transition mid-stream.

REQ-025 Rejects: start_dump with capture_done=0 -> one dump_err pulse, no ram_en. start_dump with dump_chan=3 -> one dump_err pulse, no ram_en.

REQ-026 Busy ignores: start_dump pulsed and dump_chan changed to 2 mid-dump -> the dump continues on channel 0 and no restart occurs. A spurious tx_done in SEND -> no extra byte is sent.

REQ-027 Reset mid-dump: rst_n=0 after byte 100 -> all outputs 0 and no dump_finished; a new start_dump after reset restarts at trace_end+1.
